// File: rtl/axis_arb_pkg.sv
// ============================================================================
//  Module      : axis_arb_pkg
//  Description : Shared state encoding for the AXI4-Stream round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_priority_pick.sv
// ============================================================================
//  Module      : rr_priority_pick
//  Description : Combinational round-robin pick: lowest requesting index at or
//                above ptr, wrapping, via a double-width masked search.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_pick
    import axis_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   sel,
    output logic               found
);

    localparam logic [2*NUM_REQ-1:0] c_base_mask = {{NUM_REQ{1'b0}}, {NUM_REQ{1'b1}}};

    logic [2*NUM_REQ-1:0] w_dbl_req;
    logic [2*NUM_REQ-1:0] w_dbl_mask;
    logic [2*NUM_REQ-1:0] w_masked;

    // Window [ptr, ptr+NUM_REQ-1] over the doubled vector covers every port once
    assign w_dbl_req  = {req, req};
    assign w_dbl_mask = c_base_mask << ptr;
    assign w_masked   = w_dbl_req & w_dbl_mask;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
            if (w_masked[i]) begin
                found = 1'b1;
                sel   = (i >= NUM_REQ) ? IDX_W'(i - NUM_REQ) : IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/axis_rr_arbiter.sv
// ============================================================================
//  Module      : axis_rr_arbiter
//  Description : Packet-level round-robin arbiter for NUM_REQ AXI4-Stream ports.
//                AXIS_ARB_BACK2BACK_EN removes the idle bubble between packets.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] last,
    input  logic               out_ready,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    localparam logic [IDX_W-1:0]   c_last_idx = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] c_one      = NUM_REQ'(1);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    w_ptr_nxt;
    logic [IDX_W-1:0]    w_idx_inc;
    logic [IDX_W-1:0]    w_pick_ptr;
    logic [IDX_W-1:0]    w_sel;
    logic                w_found;
    logic                w_done;
    logic [NUM_REQ-1:0]  w_sel_onehot;
    logic [NUM_REQ-1:0]  w_grant_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic                w_valid_nxt;

    // Explicit compare keeps non-power-of-2 port counts in range
    assign w_idx_inc = (grant_idx == c_last_idx) ? '0 : grant_idx + IDX_W'(1);
    assign w_done    = (r_state == ARB_LOCKED) & req[grant_idx] & out_ready & last[grant_idx];

`ifdef AXIS_ARB_BACK2BACK_EN
    assign w_pick_ptr = (r_state == ARB_LOCKED) ? w_idx_inc : r_ptr;
`else
    assign w_pick_ptr = r_ptr;
`endif

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (w_pick_ptr),
        .sel   (w_sel),
        .found (w_found)
    );

    assign w_sel_onehot = c_one << w_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ARB_IDLE;
            r_ptr       <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            grant       <= w_grant_nxt;
            grant_idx   <= w_idx_nxt;
            grant_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = grant;
        w_idx_nxt   = grant_idx;
        w_valid_nxt = grant_valid;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ARB_LOCKED;
                    w_grant_nxt = w_sel_onehot;
                    w_idx_nxt   = w_sel;
                    w_valid_nxt = 1'b1;
                end
            end
            ARB_LOCKED: begin
                // Grant is held through stalls and TVALID gaps until TLAST moves
                if (w_done) begin
                    w_ptr_nxt   = w_idx_inc;
                    w_state_nxt = ARB_IDLE;
                    w_grant_nxt = '0;
                    w_idx_nxt   = '0;
                    w_valid_nxt = 1'b0;
`ifdef AXIS_ARB_BACK2BACK_EN
                    if (w_found) begin
                        w_state_nxt = ARB_LOCKED;
                        w_grant_nxt = w_sel_onehot;
                        w_idx_nxt   = w_sel;
                        w_valid_nxt = 1'b1;
                    end
`endif
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    a_grant_onehot0: assert property (@(posedge clk) $onehot0(grant));

endmodule

`default_nettype wire

// File: tb/tb_axis_rr_arbiter.sv
// ============================================================================
//  Module      : tb_axis_rr_arbiter
//  Description : Directed testbench for axis_rr_arbiter (4-port and 3-port).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] last;
    logic       out_ready;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;

    logic [2:0] req3;
    logic [2:0] last3;
    logic       ready3;
    logic [2:0] grant3;
    logic [1:0] grant_idx3;
    logic       valid3;

    int vectors = 0;
    int errors  = 0;

    axis_rr_arbiter #(.NUM_REQ(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .last        (last),
        .out_ready   (out_ready),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    axis_rr_arbiter #(.NUM_REQ(3)) dut3 (
        .clk         (clk),
        .reset       (reset),
        .req         (req3),
        .last        (last3),
        .out_ready   (ready3),
        .grant       (grant3),
        .grant_idx   (grant_idx3),
        .grant_valid (valid3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        req       = '0;
        last      = '0;
        out_ready = 1'b0;
        req3      = '0;
        last3     = '0;
        ready3    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        req       = 4'b1111;
        last      = 4'b0000;
        out_ready = 1'b0;
        req3      = '0;
        last3     = '0;
        ready3    = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0) begin
                $display("FAIL reset_hold cyc%0d: grant=%b valid=%b idx=%0d, want 0000/0/0",
                         c, grant, grant_valid, grant_idx);
                errors++;
            end
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (grant !== 4'b0001 || grant_idx !== 2'd0 || grant_valid !== 1'b1) begin
            $display("FAIL reset_release: grant=%b idx=%0d valid=%b, want 0001/0/1",
                     grant, grant_idx, grant_valid);
            errors++;
        end
    endtask

    task automatic test_rotation;
`ifdef AXIS_ARB_BACK2BACK_EN
        int n = 5;
        int exp_idx[9] = '{0, 1, 2, 3, 0, 0, 0, 0, 0};
        int exp_v[9]   = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
`else
        int n = 9;
        int exp_idx[9] = '{0, 0, 1, 0, 2, 0, 3, 0, 0};
        int exp_v[9]   = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
`endif
        logic [3:0] exp_g;
        do_reset();
        req       = 4'b1111;
        last      = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < n; c++) begin
            tick();
            exp_g = (exp_v[c] != 0) ? (4'b0001 << exp_idx[c]) : 4'b0000;
            vectors++;
            if (grant !== exp_g || grant_idx !== 2'(exp_idx[c]) || grant_valid !== exp_v[c][0]) begin
                $display("FAIL rotation cyc%0d: grant=%b idx=%0d valid=%b, want %b/%0d/%0d",
                         c, grant, grant_idx, grant_valid, exp_g, exp_idx[c], exp_v[c]);
                errors++;
            end
        end
    endtask

    task automatic test_lock;
        logic [3:0] t_req[6]   = '{4'b1111, 4'b1111, 4'b1111, 4'b1011, 4'b1011, 4'b1111};
        logic [3:0] t_last[6]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
        logic       t_ready[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        req       = 4'b0100;
        last      = 4'b0000;
        out_ready = 1'b0;
        tick();
        vectors++;
        if (grant !== 4'b0100) begin
            $display("FAIL lock_grant: grant=%b, want 0100", grant);
            errors++;
        end
        for (int c = 0; c < 6; c++) begin
            req       = t_req[c];
            last      = t_last[c];
            out_ready = t_ready[c];
            tick();
            vectors++;
            if (grant !== 4'b0100 || grant_idx !== 2'd2) begin
                $display("FAIL lock_hold cyc%0d: grant=%b idx=%0d, want 0100/2", c, grant, grant_idx);
                errors++;
            end
        end
        req       = 4'b1111;
        last      = 4'b0100;
        out_ready = 1'b1;
        tick();
`ifndef AXIS_ARB_BACK2BACK_EN
        vectors++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
            $display("FAIL lock_release_bubble: grant=%b valid=%b, want 0000/0", grant, grant_valid);
            errors++;
        end
        tick();
`endif
        vectors++;
        if (grant !== 4'b1000 || grant_idx !== 2'd3) begin
            $display("FAIL lock_next_port: grant=%b idx=%0d, want 1000/3", grant, grant_idx);
            errors++;
        end
    endtask

    task automatic test_wrap;
        do_reset();
        req       = 4'b0100;
        last      = 4'b0100;
        out_ready = 1'b1;
        tick();
        vectors++;
        if (grant_idx !== 2'd2 || grant_valid !== 1'b1) begin
            $display("FAIL wrap_first: idx=%0d valid=%b, want 2/1", grant_idx, grant_valid);
            errors++;
        end
        req = 4'b0101;
        tick();
`ifndef AXIS_ARB_BACK2BACK_EN
        req = 4'b0001;
        tick();
`endif
        vectors++;
        if (grant_idx !== 2'd0 || grant !== 4'b0001) begin
            $display("FAIL wrap_to_zero: grant=%b idx=%0d, want 0001/0", grant, grant_idx);
            errors++;
        end
        req  = 4'b0111;
        last = 4'b0001;
        tick();
`ifndef AXIS_ARB_BACK2BACK_EN
        req = 4'b0110;
        tick();
`endif
        vectors++;
        if (grant_idx !== 2'd1 || grant !== 4'b0010) begin
            $display("FAIL wrap_skip: grant=%b idx=%0d, want 0010/1", grant, grant_idx);
            errors++;
        end
    endtask

    task automatic test_non_pow2;
`ifdef AXIS_ARB_BACK2BACK_EN
        int n = 4;
        int exp_idx[7] = '{0, 1, 2, 0, 0, 0, 0};
        int exp_v[7]   = '{1, 1, 1, 1, 0, 0, 0};
`else
        int n = 7;
        int exp_idx[7] = '{0, 0, 1, 0, 2, 0, 0};
        int exp_v[7]   = '{1, 0, 1, 0, 1, 0, 1};
`endif
        logic [2:0] exp_g;
        do_reset();
        req3   = 3'b111;
        last3  = 3'b111;
        ready3 = 1'b1;
        for (int c = 0; c < n; c++) begin
            tick();
            exp_g = (exp_v[c] != 0) ? (3'b001 << exp_idx[c]) : 3'b000;
            vectors++;
            if (grant3 !== exp_g || grant_idx3 !== 2'(exp_idx[c]) || valid3 !== exp_v[c][0]
                || grant_idx3 > 2'd2) begin
                $display("FAIL np2 cyc%0d: grant=%b idx=%0d valid=%b, want %b/%0d/%0d",
                         c, grant3, grant_idx3, valid3, exp_g, exp_idx[c], exp_v[c]);
                errors++;
            end
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        req       = 4'b0010;
        last      = 4'b0010;
        out_ready = 1'b1;
        tick();
        vectors++;
        if (grant !== 4'b0010) begin
            $display("FAIL midrst_first: grant=%b, want 0010", grant);
            errors++;
        end
        tick();
        last      = 4'b0000;
        out_ready = 1'b0;
`ifndef AXIS_ARB_BACK2BACK_EN
        tick();
`endif
        vectors++;
        if (grant !== 4'b0010 || grant_valid !== 1'b1) begin
            $display("FAIL midrst_relock: grant=%b valid=%b, want 0010/1", grant, grant_valid);
            errors++;
        end
        reset = 1'b1;
        tick();
        vectors++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0) begin
            $display("FAIL midrst_drop: grant=%b valid=%b idx=%0d, want 0000/0/0",
                     grant, grant_valid, grant_idx);
            errors++;
        end
        reset = 1'b0;
        req   = 4'b0110;
        tick();
        vectors++;
        if (grant !== 4'b0010 || grant_idx !== 2'd1) begin
            $display("FAIL midrst_ptr_zero: grant=%b idx=%0d, want 0010/1", grant, grant_idx);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_lock();
        test_wrap();
        test_non_pow2();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
